// File: rtl/mem_arb_pkg.sv
// Shared definitions for the block-RAM port arbiter: read-owner
// encoding, wait counter sizing and the default starvation bound.
package mem_arb_pkg;

  // Who issued a read in the previous cycle, so the returning RAM data
  // can be steered to the right requester.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_PER  = 2'd2
  } owner_t;

  // The starvation counter is four bits wide, so the bound is 1..15.
  localparam int WAIT_CNT_W       = 4;
  localparam int DEFAULT_MAX_WAIT = 4;

  // Next read owner given this cycle's grants. Writes and idle cycles
  // produce no response, so they leave no owner behind.
  function automatic owner_t nextOwner(input logic cpuGnt,
                                       input logic cpuWe,
                                       input logic perGnt,
                                       input logic perWe);
    if (cpuGnt && !cpuWe) begin
      return OWN_CPU;
    end
    if (perGnt && !perWe) begin
      return OWN_PER;
    end
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bus bundle around the arbiter: CPU request channel, peripheral request
// channel and the single RAM port. The arbiter takes the slave view; the
// requesters and the RAM together form the master side.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              per_req;
  logic              per_we;
  logic [ADDR_W-1:0] per_addr;
  logic [DATA_W-1:0] per_wdata;
  logic              per_gnt;
  logic              per_rvalid;
  logic [DATA_W-1:0] per_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  per_req, per_we, per_addr, per_wdata,
    output per_gnt, per_rvalid, per_rdata,
    output ram_addr, ram_we, ram_wdata,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output per_req, per_we, per_addr, per_wdata,
    input  per_gnt, per_rvalid, per_rdata,
    input  ram_addr, ram_we, ram_wdata,
    output ram_rdata
  );

endinterface

// File: rtl/starve_counter.sv
// Saturating count of consecutive cycles the CPU has been kept waiting.
// Raises force_cpu once the count reaches the bound so the arbiter can
// override the peripheral's priority.
module starve_counter
  import mem_arb_pkg::*;
#(
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input  logic clock,
  input  logic reset,
  input  logic i_inc,
  input  logic i_clear,
  output logic o_forceCpu
);

  localparam logic [WAIT_CNT_W-1:0] MAX_CNT = WAIT_CNT_W'(MAX_WAIT);

  logic [WAIT_CNT_W-1:0] r_count;
  logic [WAIT_CNT_W-1:0] w_countNext;

  // Clear wins over increment; the count holds once it hits the bound.
  always_comb begin
    w_countNext = r_count;
    if (i_clear) begin
      w_countNext = '0;
    end else if (i_inc && (r_count != MAX_CNT)) begin
      w_countNext = r_count + 1'b1;
    end
  end

  // Counter register, cleared straight away by reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else begin
      r_count <= w_countNext;
    end
  end

  assign o_forceCpu = (r_count == MAX_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-port block RAM arbiter between the CPU and a peripheral
// requester. Peripheral has fixed priority unless the CPU has waited
// MAX_WAIT cycles. Read data returns one cycle after the grant and is
// flagged to whichever requester issued that read.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int MAX_WAIT = DEFAULT_MAX_WAIT
) (
  input logic            clock,
  input logic            reset,
  mem_port_arbiter_if.slave bus
);

  owner_t            r_owner;
  owner_t            w_ownerNext;
  logic              w_cpuGnt;
  logic              w_perGnt;
  logic              w_forceCpu;
  logic              w_cntInc;
  logic              w_cntClear;
  logic [ADDR_W-1:0] r_ramAddr;
  logic [ADDR_W-1:0] w_ramAddr;
  logic              w_ramWe;
  logic [DATA_W-1:0] w_ramWdata;

  // Combinational grant: starved CPU first, then peripheral, then CPU.
  // Holding reset low suppresses every grant immediately.
  always_comb begin
    w_cpuGnt = 1'b0;
    w_perGnt = 1'b0;
    if (reset) begin
      if (bus.cpu_req && w_forceCpu) begin
        w_cpuGnt = 1'b1;
      end else if (bus.per_req) begin
        w_perGnt = 1'b1;
      end else if (bus.cpu_req) begin
        w_cpuGnt = 1'b1;
      end
    end
  end

  // RAM port mux; an idle cycle keeps the previous address and never writes.
  always_comb begin
    w_ramAddr  = r_ramAddr;
    w_ramWe    = 1'b0;
    w_ramWdata = bus.cpu_wdata;
    if (w_cpuGnt) begin
      w_ramAddr  = bus.cpu_addr;
      w_ramWe    = bus.cpu_we;
      w_ramWdata = bus.cpu_wdata;
    end else if (w_perGnt) begin
      w_ramAddr  = bus.per_addr;
      w_ramWe    = bus.per_we;
      w_ramWdata = bus.per_wdata;
    end
  end

  // Remember the last issued address so it can be held through idle cycles.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ramAddr <= '0;
    end else begin
      r_ramAddr <= w_ramAddr;
    end
  end

  // Next read owner, derived from who was granted a read this cycle.
  always_comb begin
    w_ownerNext = nextOwner(w_cpuGnt, bus.cpu_we, w_perGnt, bus.per_we);
  end

  // Owner register; reset drops any read still in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_owner <= OWN_NONE;
    end else begin
      r_owner <= w_ownerNext;
    end
  end

  // CPU waits whenever it asks and loses; any grant or withdrawal restarts it.
  assign w_cntInc   = bus.cpu_req & ~w_cpuGnt;
  assign w_cntClear = w_cpuGnt | ~bus.cpu_req;

  starve_counter #(
    .MAX_WAIT (MAX_WAIT)
  ) u_starve (
    .clock      (clock),
    .reset      (reset),
    .i_inc      (w_cntInc),
    .i_clear    (w_cntClear),
    .o_forceCpu (w_forceCpu)
  );

  assign bus.cpu_gnt    = w_cpuGnt;
  assign bus.per_gnt    = w_perGnt;
  assign bus.cpu_rvalid = reset && (r_owner == OWN_CPU);
  assign bus.per_rvalid = reset && (r_owner == OWN_PER);
  assign bus.cpu_rdata  = bus.ram_rdata;
  assign bus.per_rdata  = bus.ram_rdata;
  assign bus.ram_addr   = w_ramAddr;
  assign bus.ram_we     = w_ramWe;
  assign bus.ram_wdata  = w_ramWdata;

endmodule
